// File: rtl/xil_dmem_rd_ctl_8x16_pkg.sv
// Shared constants and types for the 8x16 distributed-memory read controller.
// Optional feature macro used by the top: XIL_DMEM_RD_LEVEL_EN.
package xil_dmem_rd_ctl_8x16_pkg;

  localparam int DATA_W_DEF = 16;
  localparam int ADR_W_DEF  = 3;
  localparam int DEPTH      = 1 << ADR_W_DEF;
  localparam int CNT_W      = ADR_W_DEF + 1;

  // Output register stage: EMPTY holds no word, FULL presents a word on o_data.
  typedef enum logic [0:0] {
    OREG_EMPTY = 1'b0,
    OREG_FULL  = 1'b1
  } oreg_st_e;

  // Next state of the output register given this cycle's load and pop.
  function automatic oreg_st_e oreg_next(input oreg_st_e st, input logic load,
                                         input logic pop);
    oreg_st_e nxt;
    case (st)
      OREG_EMPTY: begin
        if (load) nxt = OREG_FULL;
        else      nxt = OREG_EMPTY;
      end
      OREG_FULL: begin
        if (pop && !load) nxt = OREG_EMPTY;
        else              nxt = OREG_FULL;
      end
      default: nxt = OREG_EMPTY;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/xil_dmem_rd_ctl_8x16_oreg.sv
// Valid/ready output register stage for the read controller. It decides when
// a word is pulled from the memory read port and holds it until accepted.
module xil_dmem_rd_oreg
  import xil_dmem_rd_ctl_8x16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_avail,
  input  logic              i_ready,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic              o_load,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data
);

  oreg_st_e          state_q, state_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic              pop_s;
  logic              load_s;

  assign o_valid = (state_q == OREG_FULL);
  assign o_data  = data_q;
  assign o_load  = load_s;

  // Handshake decode and next-state/data selection; flush empties the stage.
  always_comb begin
    pop_s   = o_valid & i_ready;
    load_s  = i_avail & (~o_valid | pop_s);
    state_d = state_q;
    data_d  = data_q;
    if (i_flush) begin
      state_d = OREG_EMPTY;
    end else begin
      state_d = oreg_next(state_q, load_s, pop_s);
      if (load_s) begin
        data_d = i_rd_data;
      end else begin
        data_d = data_q;
      end
    end
  end

  // Output stage state and data register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= OREG_EMPTY;
      data_q  <= {DATA_W{1'b0}};
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
    end
  end

endmodule

// File: rtl/xil_dmem_rd_ctl_8x16.sv
// Read-side controller for the 8x16 two-port distributed memory. Owns the
// write and read ring pointers and the ring occupancy count, and drains words
// through the memory's asynchronous read port into a valid/ready stage.
// Optional feature macro: XIL_DMEM_RD_LEVEL_EN adds o_level and o_almost_full.
module xil_dmem_rd_ctl_8x16
  import xil_dmem_rd_ctl_8x16_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADR_W  = ADR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_flush,
  input  logic              i_push,
  output logic [ADR_W-1:0]  o_mem_wr_adr,
  output logic              o_full,
  output logic [ADR_W-1:0]  o_mem_rd_adr,
  input  logic [DATA_W-1:0] i_mem_rd_data,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  input  logic              i_ready,
`ifdef XIL_DMEM_RD_LEVEL_EN
  output logic [ADR_W:0]    o_level,
  output logic              o_almost_full,
`endif
  output logic              o_ovf_err
);

  localparam logic [ADR_W-1:0] PTR_ZERO  = {ADR_W{1'b0}};
  localparam logic [ADR_W-1:0] PTR_ONE   = {{(ADR_W-1){1'b0}}, 1'b1};
  localparam logic [ADR_W:0]   CNT_ZERO  = {(ADR_W+1){1'b0}};
  localparam logic [ADR_W:0]   CNT_ONE   = {{ADR_W{1'b0}}, 1'b1};
  localparam logic [ADR_W:0]   CNT_FULL  = {1'b1, {ADR_W{1'b0}}};

  logic [ADR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADR_W:0]   count_q, count_d;
  logic             ovf_q, ovf_d;
  logic             full_s;
  logic             push_ok_s;
  logic             load_s;

  assign full_s       = (count_q == CNT_FULL);
  assign o_full       = full_s;
  assign o_mem_wr_adr = wr_ptr_q;
  assign o_mem_rd_adr = rd_ptr_q;
  assign o_ovf_err    = ovf_q;

  xil_dmem_rd_oreg #(
    .DATA_W (DATA_W)
  ) u_oreg (
    .clk       (clk),
    .rst_n     (rst_n),
    .i_flush   (i_flush),
    .i_avail   (count_q != CNT_ZERO),
    .i_ready   (i_ready),
    .i_rd_data (i_mem_rd_data),
    .o_load    (load_s),
    .o_valid   (o_valid),
    .o_data    (o_data)
  );

  // Pointer, count and overflow next-state; flush overrides push and load.
  always_comb begin
    push_ok_s = i_push & ~full_s;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    ovf_d     = ovf_q;
    if (i_flush) begin
      wr_ptr_d = PTR_ZERO;
      rd_ptr_d = PTR_ZERO;
      count_d  = CNT_ZERO;
      ovf_d    = 1'b0;
    end else begin
      if (push_ok_s) wr_ptr_d = wr_ptr_q + PTR_ONE;
      else           wr_ptr_d = wr_ptr_q;
      if (load_s) rd_ptr_d = rd_ptr_q + PTR_ONE;
      else        rd_ptr_d = rd_ptr_q;
      case ({push_ok_s, load_s})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
      ovf_d = ovf_q | (i_push & full_s);
    end
  end

  // Ring pointers, occupancy and sticky overflow flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= PTR_ZERO;
      rd_ptr_q <= PTR_ZERO;
      count_q  <= CNT_ZERO;
      ovf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      ovf_q    <= ovf_d;
    end
  end

`ifdef XIL_DMEM_RD_LEVEL_EN
  logic [ADR_W:0] level_q, level_d;
  logic           valid_nxt_s;

  assign o_level       = level_q;
  assign o_almost_full = (count_q >= (CNT_FULL - CNT_ONE));

  // Total words held (ring plus output register) after this edge.
  always_comb begin
    valid_nxt_s = load_s | (o_valid & ~i_ready);
    if (i_flush) begin
      level_d = CNT_ZERO;
    end else begin
      level_d = count_d + {{ADR_W{1'b0}}, valid_nxt_s};
    end
  end

  // Registered fill level.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      level_q <= CNT_ZERO;
    end else begin
      level_q <= level_d;
    end
  end
`endif

endmodule

// File: tb/tb_xil_dmem_rd_ctl_8x16.sv
// Self-checking bench for xil_dmem_rd_ctl_8x16. A small memory model plays the
// 8x16 distributed RAM; a queue-based reference model predicts the outputs.
module tb_xil_dmem_rd_ctl_8x16;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        i_flush = 1'b0;
  logic        i_push = 1'b0;
  logic        i_ready = 1'b0;
  logic [15:0] wr_data = 16'h0000;
  logic [2:0]  o_mem_wr_adr;
  logic [2:0]  o_mem_rd_adr;
  logic        o_full;
  logic [15:0] i_mem_rd_data;
  logic        o_valid;
  logic [15:0] o_data;
  logic        o_ovf_err;
`ifdef XIL_DMEM_RD_LEVEL_EN
  logic [3:0]  o_level;
  logic        o_almost_full;
`endif

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [15:0] ring[$];
  logic        m_v = 1'b0;
  logic [15:0] m_d = 16'h0000;
  logic        m_ovf = 1'b0;
  int          wrp = 0;
  int          rdp = 0;
`ifdef XIL_DMEM_RD_LEVEL_EN
  int          m_lvl = 0;
`endif

  logic [15:0] mem [8];

  always #5 clk = ~clk;

  // distributed RAM: synchronous write, asynchronous read
  always @(posedge clk) begin
    if (i_push && !o_full) mem[o_mem_wr_adr] <= wr_data;
  end
  assign i_mem_rd_data = mem[o_mem_rd_adr];

  xil_dmem_rd_ctl_8x16 dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .i_flush       (i_flush),
    .i_push        (i_push),
    .o_mem_wr_adr  (o_mem_wr_adr),
    .o_full        (o_full),
    .o_mem_rd_adr  (o_mem_rd_adr),
    .i_mem_rd_data (i_mem_rd_data),
    .o_valid       (o_valid),
    .o_data        (o_data),
    .i_ready       (i_ready),
`ifdef XIL_DMEM_RD_LEVEL_EN
    .o_level       (o_level),
    .o_almost_full (o_almost_full),
`endif
    .o_ovf_err     (o_ovf_err)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_outputs();
    chk("valid", {31'd0, o_valid}, {31'd0, m_v});
    if (m_v) chk("data", {16'd0, o_data}, {16'd0, m_d});
    chk("full", {31'd0, o_full}, {31'd0, (ring.size() == 8)});
    chk("ovf", {31'd0, o_ovf_err}, {31'd0, m_ovf});
    chk("wr_adr", {29'd0, o_mem_wr_adr}, 32'(wrp));
    chk("rd_adr", {29'd0, o_mem_rd_adr}, 32'(rdp));
`ifdef XIL_DMEM_RD_LEVEL_EN
    chk("level", {28'd0, o_level}, 32'(m_lvl));
    chk("almost_full", {31'd0, o_almost_full}, {31'd0, (ring.size() >= 7)});
`endif
  endtask

  task automatic model_clear();
    ring.delete();
    m_v = 1'b0;
    m_ovf = 1'b0;
    wrp = 0;
    rdp = 0;
`ifdef XIL_DMEM_RD_LEVEL_EN
    m_lvl = 0;
`endif
  endtask

  // one clock cycle: check outputs, drive inputs, advance the model
  task automatic cyc(input logic push, input logic [15:0] data, input logic rdy,
                     input logic flush);
    logic pop, pok, ld;
    @(negedge clk);
    check_outputs();
    i_push  = push;
    wr_data = data;
    i_ready = rdy;
    i_flush = flush;
    if (flush) begin
      model_clear();
    end else begin
      pop = m_v && rdy;
      pok = push && (ring.size() < 8);
      if (push && ring.size() == 8) m_ovf = 1'b1;
      ld = (ring.size() > 0) && (!m_v || pop);
      if (ld) begin
        m_d = ring.pop_front();
        m_v = 1'b1;
        rdp = (rdp + 1) % 8;
      end else if (pop) begin
        m_v = 1'b0;
      end
      if (pok) begin
        ring.push_back(data);
        wrp = (wrp + 1) % 8;
      end
`ifdef XIL_DMEM_RD_LEVEL_EN
      m_lvl = ring.size() + int'(m_v);
`endif
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    i_push = 1'b0;
    i_ready = 1'b0;
    i_flush = 1'b0;
    model_clear();
    #1;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    // power-on reset
    do_reset();
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);

    // single push, observed two cycles later, gone the cycle after
    cyc(1'b1, 16'hA5A5, 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // fill to 9 words with consumer stalled, overflow on the 10th
    for (int i = 1; i <= 9; i++) cyc(1'b1, 16'(i), 1'b0, 1'b0);
    cyc(1'b0, 16'h0000, 1'b0, 1'b0);
    cyc(1'b1, 16'h000A, 1'b0, 1'b0);
    for (int i = 0; i < 12; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // stream 20 words back to back, pointers wrap twice
    for (int i = 0; i < 20; i++) cyc(1'b1, 16'($urandom), 1'b1, 1'b0);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // 6-word burst with ready toggling every cycle
    for (int i = 0; i < 6; i++) cyc(1'b1, 16'($urandom), 1'(i % 2), 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b0, 16'h0000, 1'(i % 2), 1'b0);

    // flush with 5 queued words and a simultaneous push
    for (int i = 0; i < 5; i++) cyc(1'b1, 16'h0B00 + 16'(i), 1'b0, 1'b0);
    cyc(1'b1, 16'hDEAD, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    // randomized traffic with occasional flush and a mid-stream reset
    for (int i = 0; i < 400; i++) begin
      if (i == 200) begin
        do_reset();
      end else begin
        cyc(1'($urandom_range(0, 9) < 6), 16'($urandom), 1'($urandom_range(0, 9) < 5),
            1'($urandom_range(0, 59) == 0));
      end
    end
    for (int i = 0; i < 12; i++) cyc(1'b0, 16'h0000, 1'b1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
